// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, op encoding and pointer-width helper for the sync FIFO
package fifo_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 9;
    localparam int DEF_PTR_W  = DEF_ADDR_W + 1;

    // Accepted operations in one cycle, packed as {write, read}
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

    // Pointers carry one extra bit so a full FIFO is distinguishable from an empty one
    function automatic int ptr_width(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_dp.sv
// rtl/fifo_ram_dp.sv - simple dual-port RAM, one synchronous write port, one registered read port
module fifo_ram_dp
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_data_d;

    // Read register loads only on an enabled read, otherwise holds the last word
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Storage array is deliberately left unreset; same-cycle read sees the old contents
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register clears on reset so data_out starts at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with occupancy count, threshold flags and sticky errors
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int AF_LVL = (2 ** ADDR_W) - 4,
    parameter int AE_LVL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_we,
    input  logic              fifo_rd,
    input  logic              err_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_afull,
    output logic              fifo_aempty,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam int PTR_W = ptr_width(ADDR_W);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LVL);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LVL);
    localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             data_valid_q, data_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    fifo_op_e         op;

    // Status flags decode from the registered count only
    always_comb begin
        full        = (count_q == DEPTH_C);
        empty       = (count_q == '0);
        fifo_afull  = (count_q >= AF_C);
        fifo_aempty = (count_q <= AE_C);
    end

    // Requests are accepted only when the FIFO has room / has data
    always_comb begin
        wr_acc = fifo_we && !full;
        rd_acc = fifo_rd && !empty;
        op     = fifo_op_e'({wr_acc, rd_acc});
    end

    // Next-state for pointers, count, read-valid pulse and sticky errors
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        data_valid_d = rd_acc;
        case (op)
            OP_WR: begin
                wptr_d  = wptr_q + ONE_C;
                count_d = count_q + ONE_C;
            end
            OP_RD: begin
                rptr_d  = rptr_q + ONE_C;
                count_d = count_q - ONE_C;
            end
            OP_RW: begin
                wptr_d = wptr_q + ONE_C;
                rptr_d = rptr_q + ONE_C;
            end
            default: begin
            end
        endcase
        // A new error in the same cycle as err_clr wins
        overflow_d  = (overflow_q && !err_clr) || (fifo_we && !wr_acc);
        underflow_d = (underflow_q && !err_clr) || (fifo_rd && !rd_acc);
    end

    // Control state registers; reset overrides any request in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    fifo_ram_dp #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_acc && !rst),
        .wr_addr(wptr_q[ADDR_W-1:0]),
        .wr_data(data_in),
        .rd_en  (rd_acc && !rst),
        .rd_addr(rptr_q[ADDR_W-1:0]),
        .rd_data(data_out)
    );

    assign data_valid     = data_valid_q;
    assign fifo_full      = full;
    assign fifo_empty     = empty;
    assign fifo_count     = count_q;
    assign fifo_overflow  = overflow_q;
    assign fifo_underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed and randomized bench for sync_fifo_param against a queue model
module tb_sync_fifo_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int AF_LVL = 12;
    localparam int AE_LVL = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              fifo_we = 1'b0;
    logic              fifo_rd = 1'b0;
    logic              err_clr = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_afull;
    logic              fifo_aempty;
    logic [ADDR_W:0]   fifo_count;
    logic              fifo_overflow;
    logic              fifo_underflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic [31:0] m_dout = '0;
    logic        m_valid = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    sync_fifo_param #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .AF_LVL(AF_LVL),
        .AE_LVL(AE_LVL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .fifo_we       (fifo_we),
        .fifo_rd       (fifo_rd),
        .err_clr       (err_clr),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .fifo_afull    (fifo_afull),
        .fifo_aempty   (fifo_aempty),
        .fifo_count    (fifo_count),
        .fifo_overflow (fifo_overflow),
        .fifo_underflow(fifo_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        chk("count",      32'(fifo_count),     32'(n));
        chk("empty",      32'(fifo_empty),     32'(n == 0));
        chk("full",       32'(fifo_full),      32'(n == DEPTH));
        chk("afull",      32'(fifo_afull),     32'(n >= AF_LVL));
        chk("aempty",     32'(fifo_aempty),    32'(n <= AE_LVL));
        chk("overflow",   32'(fifo_overflow),  32'(m_ovf));
        chk("underflow",  32'(fifo_underflow), 32'(m_unf));
        chk("data_valid", 32'(data_valid),     32'(m_valid));
        chk("data_out",   data_out,            m_dout);
    endtask

    // One clock: drive inputs, advance the model by the FIFO rules, then compare
    task automatic step(input logic we, input logic rd, input logic [31:0] din,
                        input logic clr, input logic r);
        logic wacc;
        logic racc;
        fifo_we = we;
        fifo_rd = rd;
        data_in = din;
        err_clr = clr;
        rst     = r;
        if (r) begin
            mq.delete();
            m_dout  = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            wacc = we && (mq.size() < DEPTH);
            racc = rd && (mq.size() > 0);
            if (racc) begin
                m_dout = mq.pop_front();
            end
            m_valid = racc;
            if (wacc) begin
                mq.push_back(din);
            end
            m_ovf = (m_ovf && !clr) || (we && !wacc);
            m_unf = (m_unf && !clr) || (rd && !racc);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        // Reset state
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("rst_empty",  32'(fifo_empty),  32'd1);
        chk("rst_aempty", 32'(fifo_aempty), 32'd1);
        chk("rst_full",   32'(fifo_full),   32'd0);
        chk("rst_dout",   data_out,         32'd0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Fill with 0..15
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 32'(i), 1'b0, 1'b0);
        end
        chk("fill_full", 32'(fifo_full), 32'd1);

        // Write while full
        step(1'b1, 1'b0, 32'hDEAD, 1'b0, 1'b0);
        chk("ovf_set",   32'(fifo_overflow), 32'd1);
        chk("ovf_count", 32'(fifo_count),    32'd16);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("ovf_clr",   32'(fifo_overflow), 32'd0);

        // Drain, each word one cycle after its read
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, '0, 1'b0, 1'b0);
            chk("drain_data",  data_out,         32'(i));
            chk("drain_valid", 32'(data_valid),  32'd1);
        end
        chk("drain_empty", 32'(fifo_empty), 32'd1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("valid_pulse", 32'(data_valid), 32'd0);

        // Read on empty, then simultaneous write+read on empty
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        chk("unf_set",   32'(fifo_underflow), 32'd1);
        chk("unf_valid", 32'(data_valid),     32'd0);
        step(1'b1, 1'b1, 32'hA5, 1'b0, 1'b0);
        chk("we_rd_empty_count", 32'(fifo_count), 32'd1);
        chk("we_rd_empty_valid", 32'(data_valid), 32'd0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        chk("a5_read", data_out, 32'hA5);

        // err_clr colliding with a new underflow leaves the flag set
        step(1'b0, 1'b1, '0, 1'b1, 1'b0);
        chk("clr_vs_err", 32'(fifo_underflow), 32'd1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("unf_clr", 32'(fifo_underflow), 32'd0);

        // Threshold boundaries
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
            if (i == 4) chk("ae_at_4", 32'(fifo_aempty), 32'd1);
            if (i == 5) chk("ae_at_5", 32'(fifo_aempty), 32'd0);
            if (i == 11) chk("af_at_11", 32'(fifo_afull), 32'd0);
            if (i == 12) chk("af_at_12", 32'(fifo_afull), 32'd1);
        end
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        chk("af_back_11", 32'(fifo_afull), 32'd0);

        // Bring occupancy to 8, then stream through the pointer wrap
        for (int i = 0; i < 16 && mq.size() > 8; i++) begin
            step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
        end
        chk("wrap_count",  32'(fifo_count),  32'd8);
        chk("wrap_afull",  32'(fifo_afull),  32'd0);
        chk("wrap_aempty", 32'(fifo_aempty), 32'd0);

        // Randomized traffic including occasional err_clr and reset
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 99) == 0));
        end

        // Reset mid-run at count 9 with a write pending
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'd9);
        step(1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b1);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_empty", 32'(fifo_empty), 32'd1);
        chk("mid_rst_dout",  data_out,        32'd0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0);
        chk("post_rst_unf",   32'(fifo_underflow), 32'd1);
        chk("post_rst_valid", 32'(data_valid),     32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-4, almost-full threshold in entries.
REQ-004 SHALL have parameter AE_LVL, default 4, almost-empty threshold in entries.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port data_in, input, DATA_W, write data.
REQ-008 SHALL have port fifo_we, input, 1, write request.
REQ-009 SHALL have port fifo_rd, input, 1, read request.
REQ-010 SHALL have port err_clr, input, 1, clears the sticky error flags.
REQ-011 SHALL have port data_out, output, DATA_W, registered read data.
REQ-012 SHALL have port data_valid, output, 1, one-cycle pulse marking new data_out.
REQ-013 SHALL have port fifo_full, fifo_empty, fifo_afull, fifo_aempty, output, 1 each, status flags.
REQ-014 SHALL have port fifo_count, output, ADDR_W+1, current occupancy 0..DEPTH.
REQ-015 SHALL have port fifo_overflow, fifo_underflow, output, 1 each, sticky error flags.

Function
REQ-016 Write accepted iff fifo_we && !fifo_full; the entry at wptr is written and wptr increments by 1.
REQ-017 Read accepted iff fifo_rd && !fifo_empty; the entry at rptr is registered onto data_out and rptr increments by 1.
REQ-018 Read latency SHALL be 1 cycle: data_out and data_valid=1 appear on the edge after the accepted read; data_out holds its value otherwise.
REQ-019 wptr/rptr SHALL be ADDR_W+1 bits wide; the low ADDR_W bits address the memory; wrap from DEPTH-1 to 0 without gaps.
REQ-020 fifo_count +1 on write-only, -1 on read-only, unchanged on both accepted or none.
REQ-021 fifo_full = (count==DEPTH); fifo_empty = (count==0); fifo_afull = (count>=AF_LVL); fifo_aempty = (count<=AE_LVL); all decoded from registered count.
REQ-022 Simultaneous we+rd while full: read accepted, write rejected, overflow set.
REQ-023 Simultaneous we+rd while empty: write accepted, read rejected, underflow set; data_valid stays 0.
REQ-024 Rejected write SHALL set fifo_overflow; rejected read SHALL set fifo_underflow; memory, pointers and count SHALL stay unchanged.
REQ-025 Error flags SHALL be sticky until err_clr or rst; if err_clr and a new error occur in the same cycle, the flag SHALL end set.
REQ-026 A read SHALL never return a word written in the same cycle (no write-to-read bypass).

Reset
REQ-027 On rst: wptr=0, rptr=0, count=0, data_out=0, data_valid=0, overflow=0, underflow=0; hence empty=1, aempty=1, full=0, afull=0.
REQ-028 Memory contents SHALL NOT be reset; rst SHALL override fifo_we/fifo_rd in the same cycle.
REQ-029 Reset mid-operation SHALL discard all stored entries; the first read after reset SHALL be underflow unless a write has been accepted.

Structure
REQ-030 Shared package fifo_pkg SHALL hold default DATA_W/ADDR_W and a pointer-width helper constant (ADDR_W+1).
REQ-031 Storage SHALL be a sub-module fifo_ram_dp: simple dual-port RAM, DATA_W x DEPTH, one synchronous write port, one registered read port with enable.
REQ-032 Pointer, count, flag and error logic SHALL reside in sync_fifo_param.

Verification (bench DATA_W=32, ADDR_W=4, DEPTH=16, AF_LVL=12, AE_LVL=4)
REQ-033 Fill/drain: 16 writes of 0x0..0xF, then 16 reads -> data_out 0x0..0xF in order, each 1 cycle after its read; full after the 16th write, empty after the 16th read.
REQ-034 Overflow: 17th write of 0xDEAD while full -> overflow=1, count=16, 0xDEAD is never read; err_clr -> overflow=0.
REQ-035 Underflow and empty-simultaneous: rd on empty -> underflow=1, data_valid=0; we+rd on empty with 0xA5 -> count=1, the next read returns 0xA5.
REQ-036 Wrap: 40 cycles of continuous we+rd at count=8 -> count stays 8; data sequence intact across the pointer wrap; afull/aempty stay 0.
REQ-037 Thresholds: count 4 -> aempty=1; count 5 -> aempty=0; count 12 -> afull=1; count 11 -> afull=0.
REQ-038 Reset mid-run: rst at count=9 with we=1 -> next cycle count=0, empty=1, data_out=0, and the write is not stored.
